// File: rtl/modulo_codificador_7seg_bcd.sv
// Seven-segment bus snooper: debounces a multiplexed active-low display drive
// and recovers one hex nibble per digit, flagging undecodable patterns.
module modulo_codificador_7seg_bcd #(
   parameter int unsigned STABLE_CYCLES = 4
) (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic [7:0]  IN_SEGS,
   input  logic [3:0]  IN_DIG,
   output logic [15:0] OUT_BCD,
   output logic [3:0]  OUT_VALID,
   output logic        OUT_ERR,
   output logic        OUT_DONE
);

   typedef enum logic [1:0] {StIdle, StFilter, StHold} state_e;

   localparam logic [3:0] StableCnt = 4'(STABLE_CYCLES);

   logic [7:0]  seg_s1_q, seg_s2_q;
   logic [3:0]  dig_s1_q, dig_s2_q;
   logic [11:0] prev_q;
   state_e      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [15:0] bcd_q, bcd_d;
   logic [3:0]  valid_q, valid_d;
   logic        err_q, err_d;
   logic        done_q, done_d;

   logic [11:0] s_cur;
   logic        same;
   logic        dig_ok;
   logic [1:0]  idx;
   logic        hit;
   logic [3:0]  nib;
   logic [3:0]  cnt_inc;
   logic        capture;

   assign s_cur   = {seg_s2_q, dig_s2_q};
   assign same    = (s_cur == prev_q);
   assign cnt_inc = (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;

   always_comb begin
      dig_ok = 1'b1;
      idx    = 2'd0;
      case (dig_s2_q)
         4'b1110: idx = 2'd0;
         4'b1101: idx = 2'd1;
         4'b1011: idx = 2'd2;
         4'b0111: idx = 2'd3;
         default: dig_ok = 1'b0;
      endcase
   end

   // dp is forced to 1 so the table can be written in the usual dp-off hex form
   always_comb begin
      hit = 1'b1;
      nib = 4'h0;
      case ({seg_s2_q[7:1], 1'b1})
         8'h03: nib = 4'h0;
         8'h9F: nib = 4'h1;
         8'h25: nib = 4'h2;
         8'h0D: nib = 4'h3;
         8'h99: nib = 4'h4;
         8'h49: nib = 4'h5;
         8'h41: nib = 4'h6;
         8'h1F: nib = 4'h7;
         8'h01: nib = 4'h8;
         8'h09: nib = 4'h9;
         8'h11: nib = 4'hA;
         8'hC1: nib = 4'hB;
         8'h63: nib = 4'hC;
         8'h85: nib = 4'hD;
         8'h61: nib = 4'hE;
         8'h71: nib = 4'hF;
         default: hit = 1'b0;
      endcase
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      capture = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (dig_ok) begin
               state_d = StFilter;
               cnt_d   = 4'd1;
            end else begin
               cnt_d = 4'd0;
            end
         end
         StFilter: begin
            if (!dig_ok) begin
               state_d = StIdle;
               cnt_d   = 4'd0;
            end else if (!same) begin
               cnt_d = 4'd1;
            end else begin
               cnt_d = cnt_inc;
               if (cnt_inc == StableCnt) begin
                  capture = 1'b1;
                  state_d = StHold;
               end
            end
         end
         StHold: begin
            if (!dig_ok) begin
               state_d = StIdle;
               cnt_d   = 4'd0;
            end else if (!same) begin
               state_d = StFilter;
               cnt_d   = 4'd1;
            end
         end
         default: begin
            state_d = StIdle;
            cnt_d   = 4'd0;
         end
      endcase
   end

   // Frame clear is applied first so a capture on the same edge keeps its bit
   always_comb begin
      bcd_d   = bcd_q;
      valid_d = valid_q;
      err_d   = 1'b0;
      done_d  = 1'b0;
      if (valid_q == 4'hF) begin
         valid_d = 4'h0;
         done_d  = 1'b1;
      end
      if (capture) begin
         if (hit) begin
            bcd_d[{idx, 2'b00} +: 4] = nib;
            valid_d[idx]             = 1'b1;
         end else begin
            valid_d[idx] = 1'b0;
            err_d        = 1'b1;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         seg_s1_q <= 8'hFF;
         seg_s2_q <= 8'hFF;
         dig_s1_q <= 4'hF;
         dig_s2_q <= 4'hF;
         prev_q   <= 12'hFFF;
         state_q  <= StIdle;
         cnt_q    <= 4'd0;
         bcd_q    <= 16'h0000;
         valid_q  <= 4'h0;
         err_q    <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         seg_s1_q <= IN_SEGS;
         seg_s2_q <= seg_s1_q;
         dig_s1_q <= IN_DIG;
         dig_s2_q <= dig_s1_q;
         prev_q   <= s_cur;
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         bcd_q    <= bcd_d;
         valid_q  <= valid_d;
         err_q    <= err_d;
         done_q   <= done_d;
      end
   end

   assign OUT_BCD   = bcd_q;
   assign OUT_VALID = valid_q;
   assign OUT_ERR   = err_q;
   assign OUT_DONE  = done_q;

endmodule

// File: tb/tb_modulo_codificador_7seg_bcd.sv
// Directed bench for the seven-segment snooper: one task per scenario, inputs
// driven on the falling edge, outputs sampled on the falling edge.
module tb_modulo_codificador_7seg_bcd;

   logic        clk;
   logic        rst_n;
   logic [7:0]  in_segs;
   logic [3:0]  in_dig;
   logic [15:0] out_bcd;
   logic [3:0]  out_valid;
   logic        out_err;
   logic        out_done;

   int n_cmp = 0;
   int n_bad = 0;

   int done_cnt   = 0;
   int err_cnt    = 0;
   int done_twice = 0;
   int err_twice  = 0;
   logic done_prev = 1'b0;
   logic err_prev  = 1'b0;

   modulo_codificador_7seg_bcd #(
      .STABLE_CYCLES(4)
   ) dut (
      .CLK      (clk),
      .RST_N    (rst_n),
      .IN_SEGS  (in_segs),
      .IN_DIG   (in_dig),
      .OUT_BCD  (out_bcd),
      .OUT_VALID(out_valid),
      .OUT_ERR  (out_err),
      .OUT_DONE (out_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Pulse monitor, sampled shortly after each rising edge
   always @(posedge clk) begin
      #2;
      if (out_done === 1'b1) begin
         done_cnt++;
         if (done_prev) done_twice++;
      end
      if (out_err === 1'b1) begin
         err_cnt++;
         if (err_prev) err_twice++;
      end
      done_prev = out_done;
      err_prev  = out_err;
   end

   task automatic hold(input logic [3:0] d, input logic [7:0] s, input int n);
      in_dig  = d;
      in_segs = s;
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      hold(4'hF, 8'hFF, 2);
      rst_n = 1'b1;
      hold(4'hF, 8'hFF, 2);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      hold(4'hE, 8'h25, 3);
      n_cmp++; if (out_bcd !== 16'h0000) begin n_bad++;
         $display("FAIL reset_bcd got %h want 0000", out_bcd); end
      n_cmp++; if (out_valid !== 4'h0) begin n_bad++;
         $display("FAIL reset_valid got %b want 0000", out_valid); end
      n_cmp++; if (out_err !== 1'b0) begin n_bad++;
         $display("FAIL reset_err got %b want 0", out_err); end
      n_cmp++; if (out_done !== 1'b0) begin n_bad++;
         $display("FAIL reset_done got %b want 0", out_done); end
      rst_n = 1'b1;
      hold(4'hF, 8'hFF, 4);
   endtask

   // Applied ahead of edge n, capture lands on edge n+5 with STABLE_CYCLES=4
   task automatic test_single_capture();
      int e0;
      do_reset();
      e0 = err_cnt;
      hold(4'hE, 8'h25, 5);
      n_cmp++; if (out_valid !== 4'h0) begin n_bad++;
         $display("FAIL single_early got %b want 0000", out_valid); end
      hold(4'hE, 8'h25, 1);
      n_cmp++; if (out_valid !== 4'b0001) begin n_bad++;
         $display("FAIL single_valid got %b want 0001", out_valid); end
      n_cmp++; if (out_bcd !== 16'h0002) begin n_bad++;
         $display("FAIL single_bcd got %h want 0002", out_bcd); end
      hold(4'hE, 8'h25, 4);
      n_cmp++; if (err_cnt - e0 !== 0) begin n_bad++;
         $display("FAIL single_err got %0d want 0", err_cnt - e0); end
      n_cmp++; if (out_valid !== 4'b0001) begin n_bad++;
         $display("FAIL single_hold got %b want 0001", out_valid); end
   endtask

   task automatic test_full_frame();
      int d0, e0;
      do_reset();
      d0 = done_cnt;
      e0 = err_cnt;
      hold(4'hE, 8'h9F, 8);
      hold(4'hD, 8'h0D, 8);
      hold(4'hB, 8'h99, 8);
      n_cmp++; if (out_valid !== 4'b0111) begin n_bad++;
         $display("FAIL frame_partial got %b want 0111", out_valid); end
      hold(4'h7, 8'h71, 8);
      hold(4'hF, 8'hFF, 4);
      n_cmp++; if (out_bcd !== 16'hF431) begin n_bad++;
         $display("FAIL frame_bcd got %h want F431", out_bcd); end
      n_cmp++; if (out_valid !== 4'h0) begin n_bad++;
         $display("FAIL frame_valid got %b want 0000", out_valid); end
      n_cmp++; if (done_cnt - d0 !== 1) begin n_bad++;
         $display("FAIL frame_done got %0d want 1", done_cnt - d0); end
      n_cmp++; if (err_cnt - e0 !== 0) begin n_bad++;
         $display("FAIL frame_err got %0d want 0", err_cnt - e0); end
   endtask

   task automatic test_bounce();
      do_reset();
      for (int i = 0; i < 10; i++) hold(4'hE, (i % 2 == 1) ? 8'h9F : 8'h03, 2);
      n_cmp++; if (out_valid !== 4'h0) begin n_bad++;
         $display("FAIL bounce_nocap got %b want 0000", out_valid); end
      hold(4'hE, 8'h9F, 8);
      n_cmp++; if (out_bcd[3:0] !== 4'h1) begin n_bad++;
         $display("FAIL bounce_nib got %h want 1", out_bcd[3:0]); end
      n_cmp++; if (out_valid !== 4'b0001) begin n_bad++;
         $display("FAIL bounce_valid got %b want 0001", out_valid); end
   endtask

   task automatic test_error();
      int e0;
      do_reset();
      hold(4'hD, 8'h25, 8);
      n_cmp++; if (out_valid !== 4'b0010) begin n_bad++;
         $display("FAIL err_pre_valid got %b want 0010", out_valid); end
      e0 = err_cnt;
      hold(4'hD, 8'hFF, 8);
      n_cmp++; if (err_cnt - e0 !== 1) begin n_bad++;
         $display("FAIL err_pulse got %0d want 1", err_cnt - e0); end
      n_cmp++; if (out_valid !== 4'h0) begin n_bad++;
         $display("FAIL err_valid got %b want 0000", out_valid); end
      n_cmp++; if (out_bcd !== 16'h0020) begin n_bad++;
         $display("FAIL err_bcd got %h want 0020", out_bcd); end
   endtask

   task automatic test_invalid_dig();
      int e0;
      do_reset();
      e0 = err_cnt;
      hold(4'hC, 8'h03, 20);
      hold(4'hF, 8'h03, 20);
      n_cmp++; if (out_valid !== 4'h0) begin n_bad++;
         $display("FAIL baddig_valid got %b want 0000", out_valid); end
      n_cmp++; if (err_cnt - e0 !== 0) begin n_bad++;
         $display("FAIL baddig_err got %0d want 0", err_cnt - e0); end
      // dp toggles every 3 cycles: never 4 identical samples
      for (int i = 0; i < 6; i++) hold(4'hE, (i % 2 == 1) ? 8'h9E : 8'h9F, 3);
      n_cmp++; if (out_valid !== 4'h0) begin n_bad++;
         $display("FAIL dp_nocap got %b want 0000", out_valid); end
      hold(4'hE, 8'h9E, 8);
      n_cmp++; if (out_bcd !== 16'h0001) begin n_bad++;
         $display("FAIL dp_bcd got %h want 0001", out_bcd); end
      n_cmp++; if (out_valid !== 4'b0001) begin n_bad++;
         $display("FAIL dp_valid got %b want 0001", out_valid); end
   endtask

   task automatic test_recapture();
      int d0;
      do_reset();
      d0 = done_cnt;
      hold(4'hE, 8'h9F, 8);
      hold(4'hE, 8'h25, 8);
      n_cmp++; if (out_bcd !== 16'h0002) begin n_bad++;
         $display("FAIL recap_bcd got %h want 0002", out_bcd); end
      n_cmp++; if (out_valid !== 4'b0001) begin n_bad++;
         $display("FAIL recap_valid got %b want 0001", out_valid); end
      n_cmp++; if (done_cnt - d0 !== 0) begin n_bad++;
         $display("FAIL recap_done got %0d want 0", done_cnt - d0); end
   endtask

   task automatic test_reset_mid();
      int d0;
      do_reset();
      d0 = done_cnt;
      hold(4'hE, 8'h03, 8);
      hold(4'hD, 8'h25, 8);
      hold(4'hB, 8'h0D, 8);
      n_cmp++; if (out_valid !== 4'b0111) begin n_bad++;
         $display("FAIL mid_pre got %b want 0111", out_valid); end
      hold(4'h7, 8'h99, 3);
      rst_n = 1'b0;
      @(negedge clk);
      n_cmp++; if (out_bcd !== 16'h0000) begin n_bad++;
         $display("FAIL mid_rst_bcd got %h want 0000", out_bcd); end
      n_cmp++; if (out_valid !== 4'h0) begin n_bad++;
         $display("FAIL mid_rst_valid got %b want 0000", out_valid); end
      rst_n = 1'b1;
      hold(4'h7, 8'h99, 8);
      n_cmp++; if (out_valid !== 4'b1000) begin n_bad++;
         $display("FAIL mid_d3_valid got %b want 1000", out_valid); end
      n_cmp++; if (done_cnt - d0 !== 0) begin n_bad++;
         $display("FAIL mid_nodone got %0d want 0", done_cnt - d0); end
      hold(4'hE, 8'h03, 8);
      hold(4'hD, 8'h25, 8);
      hold(4'hB, 8'h0D, 8);
      hold(4'hF, 8'hFF, 4);
      n_cmp++; if (done_cnt - d0 !== 1) begin n_bad++;
         $display("FAIL mid_done got %0d want 1", done_cnt - d0); end
      n_cmp++; if (out_valid !== 4'h0) begin n_bad++;
         $display("FAIL mid_valid got %b want 0000", out_valid); end
      n_cmp++; if (out_bcd !== 16'h4320) begin n_bad++;
         $display("FAIL mid_bcd got %h want 4320", out_bcd); end
   endtask

   task automatic test_pulse_width();
      n_cmp++; if (done_twice !== 0) begin n_bad++;
         $display("FAIL done_width got %0d doubles want 0", done_twice); end
      n_cmp++; if (err_twice !== 0) begin n_bad++;
         $display("FAIL err_width got %0d doubles want 0", err_twice); end
   endtask

   initial begin
      rst_n   = 1'b0;
      in_segs = 8'hFF;
      in_dig  = 4'hF;
      test_reset();
      test_single_capture();
      test_full_frame();
      test_bounce();
      test_error();
      test_invalid_dig();
      test_recapture();
      test_reset_mid();
      test_pulse_width();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
